spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts per-channel spikes over back-to-back windows and
// drains each completed window's counts one channel per handshake.
module spike_rate_decoder #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   spike_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_chan,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [0:0]                 state_reg;
  logic [WIN_W-1:0]           win_cnt_reg;
  logic [NCH-1:0][CNT_W-1:0]  cnt_reg;
  logic [NCH-1:0][CNT_W-1:0]  cnt_inc;
  logic [NCH-1:0][CNT_W-1:0]  buf_reg;
  logic                       buf_full_reg;
  logic [CH_W-1:0]            ptr_reg;
  logic                       overrun_reg;

  logic [WIN_W-1:0] eff_len;
  logic             load;
  logic             in_count;
  logic             last_sample;
  logic             abort;
  logic             xfer;
  logic             xfer_last;
  logic             buf_free;
  logic             snap;
  logic             drop;

  // Saturating increment per channel; this is what the counters hold after a sample edge.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_inc
      assign cnt_inc[gi] = (spike_in[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                           ? cnt_reg[gi] + CNT_W'(1) : cnt_reg[gi];
    end
  endgenerate

  assign eff_len     = (window_len == '0) ? WIN_W'(1) : window_len;
  assign load        = (state_reg == IDLE) && enable;
  assign in_count    = (state_reg == COUNT);
  assign last_sample = in_count && (win_cnt_reg == WIN_W'(1));
  // The final sample edge always completes the window; enable only decides whether another follows.
  assign abort       = in_count && !enable && !last_sample;
  assign xfer        = buf_full_reg && out_ready;
  assign xfer_last   = xfer && (ptr_reg == CH_W'(NCH - 1));
  assign buf_free    = !buf_full_reg || xfer_last;
  assign snap        = last_sample && buf_free;
  assign drop        = last_sample && !buf_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      win_cnt_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      if (load || abort || last_sample) begin
        cnt_reg <= '0;
      end else if (in_count) begin
        cnt_reg <= cnt_inc;
      end

      if (load || last_sample) begin
        win_cnt_reg <= eff_len;
      end else if (in_count && !abort) begin
        win_cnt_reg <= win_cnt_reg - WIN_W'(1);
      end

      case (state_reg)
        IDLE:    if (enable) state_reg <= COUNT;
        COUNT:   if (!enable) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Drain path runs independently of the counting FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      ptr_reg      <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (snap) begin
        buf_reg      <= cnt_inc;
        buf_full_reg <= 1'b1;
        ptr_reg      <= '0;
      end else if (xfer) begin
        if (xfer_last) begin
          buf_full_reg <= 1'b0;
          ptr_reg      <= '0;
        end else begin
          ptr_reg <= ptr_reg + CH_W'(1);
        end
      end

      if (drop) overrun_reg <= 1'b1;
    end
  end

  assign out_valid = buf_full_reg;
  assign out_chan  = ptr_reg;
  assign out_count = buf_reg[ptr_reg];
  assign busy      = in_count;
  assign overrun   = overrun_reg;

endmodule
